// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the datapath.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic is_div_op(input logic [1:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply/divide unit writing the architectural HI/LO pair.
// Signed operations run on magnitudes; the sign is restored in the FIX state.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ZERO_W  = '0;
    localparam logic [W2-1:0]    ZERO_2W = '0;

    state_e            state_reg, state_next;
    logic [1:0]        op_reg;
    logic [WIDTH-1:0]  mcand_reg;
    logic [W2-1:0]     acc_reg;
    logic [CW-1:0]     count_reg;
    logic              neg_res_reg, neg_rem_reg, div0_reg;
    logic [WIDTH-1:0]  hi_reg, lo_reg;
    logic              done_reg;

    // Operand conditioning at start: magnitudes plus result-sign flags
    logic              op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;

    always_comb begin
        op_signed = is_signed_op(op);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? (ZERO_W - a) : a;
        b_mag     = b_neg ? (ZERO_W - b) : b;
    end

    // One radix-2 step. Multiply keeps {partial, multiplier} in acc; divide keeps
    // {remainder, dividend/quotient} and shifts quotient bits in at the bottom.
    logic [WIDTH-1:0]  mul_addend;
    logic [WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [W2-1:0]     acc_step;

    always_comb begin
        mul_addend = acc_reg[0] ? mcand_reg : ZERO_W;
        mul_sum    = {1'b0, acc_reg[W2-1:WIDTH]} + {1'b0, mul_addend};
        div_shift  = {acc_reg[W2-1:WIDTH], acc_reg[WIDTH-1]};
        div_diff   = div_shift - {1'b0, mcand_reg};
        if (is_div_op(op_reg)) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    // Sign fixup. Divide-by-zero yields an all-ones quotient; the remainder path
    // re-applies the dividend sign to |a|, which reproduces a exactly.
    logic [W2-1:0]     prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_res_reg ? (ZERO_2W - acc_reg) : acc_reg;
        quo_fix  = div0_reg ? '1
                 : (neg_res_reg ? (ZERO_W - acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0]);
        rem_fix  = neg_rem_reg ? (ZERO_W - acc_reg[W2-1:WIDTH]) : acc_reg[W2-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (start) state_next = S_CALC;
                S_CALC:  if (count_reg == '0) state_next = S_FIX;
                S_FIX:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state_reg == S_CALC) || (state_reg == S_FIX);
        stall = busy & hilo_rd;
        done  = done_reg;
        hi    = hi_reg;
        lo    = lo_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg      <= OP_MULT;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // A flush cancels whatever this cycle would have done, moves included
            if (!abort) begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            op_reg      <= op;
                            mcand_reg   <= is_div_op(op) ? b_mag : a_mag;
                            acc_reg     <= {ZERO_W, (is_div_op(op) ? a_mag : b_mag)};
                            count_reg   <= CW'(WIDTH - 1);
                            neg_res_reg <= a_neg ^ b_neg;
                            neg_rem_reg <= a_neg;
                            div0_reg    <= (b == ZERO_W);
                        end else begin
                            if (mthi) hi_reg <= a;
                            if (mtlo) lo_reg <= a;
                        end
                    end
                    S_CALC: begin
                        acc_reg   <= acc_step;
                        count_reg <= count_reg - CW'(1);
                    end
                    S_FIX: begin
                        if (is_div_op(op_reg)) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quo_fix;
                        end else begin
                            hi_reg <= prod_fix[W2-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end
                        done_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
